// File: rtl/disp_stream_buffer.sv
// disp_stream_buffer: elastic FWFT output stage for the disparity stream.
// The upstream pipeline cannot stall, so every valid input beat is either
// written or discarded. On overflow the rest of the frame is dropped and the
// writer waits for the next start-of-frame (tuser) before storing again.
module disp_stream_buffer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DEPTH            = 512,
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_disp_tdata,
    input  logic                        s_axis_disp_tvalid,
    input  logic                        s_axis_disp_tuser,
    input  logic                        s_axis_disp_tlast,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic                        frame_drop,
    output logic [DROP_CNT_WIDTH-1:0]   drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic                        user;
        logic                        last;
        logic [AXIS_TDATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } wr_state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    entry_t        in_entry;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    wr_state_t     state;
    wr_state_t     state_next;
    logic          pop;
    logic          space;
    logic          wr_en;
    logic          drop_evt;

    assign in_entry        = '{user: s_axis_disp_tuser, last: s_axis_disp_tlast,
                               data: s_axis_disp_tdata};
    assign m_axis_tvalid   = (count != '0);
    assign pop             = m_axis_tvalid & m_axis_tready;
    // Space counts the same-cycle pop, so a full FIFO can still accept a beat.
    assign space           = (count < CW'(DEPTH)) | pop;
    assign rd_next         = rd_ptr + AW'(pop);
    assign count_after_pop = count - CW'(pop);

    assign m_axis_tdata = head.data;
    assign m_axis_tuser = head.user;
    assign m_axis_tlast = head.last;
    assign fifo_level   = count;

    // Write-side FSM: decide whether the current valid beat is stored or dropped.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        wr_en      = 1'b0;
        drop_evt   = 1'b0;
        if (s_axis_disp_tvalid) begin
            unique case (state)
                ST_SYNC: begin
                    if (s_axis_disp_tuser && space) begin
                        wr_en      = 1'b1;
                        state_next = ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (space) begin
                        wr_en = 1'b1;
                    end else begin
                        drop_evt   = 1'b1;
                        state_next = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (s_axis_disp_tuser) begin
                        if (space) begin
                            wr_en      = 1'b1;
                            state_next = ST_PASS;
                        end else begin
                            drop_evt = 1'b1;
                        end
                    end
                end
                default: state_next = ST_SYNC;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: sequential state is always assigned with <= so all flops update from pre-edge values.
        if (!aresetn) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Storage array write port.
    // NOTE: the array is deliberately not reset; occupancy is tracked by count, so stale words are never observed.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_next;
            unique case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered head entry: bypass the incoming beat into an empty FIFO,
    // otherwise advance to the next stored word on pop, else hold.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head <= '0;
        end else if (wr_en && (count_after_pop == '0)) begin
            head <= in_entry;
        end else if (pop && (count_after_pop != '0)) begin
            head <= mem[rd_next];
        end
    end

    // Drop statistics: one-cycle pulse and saturating frame counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_drop <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            frame_drop <= drop_evt;
            if (drop_evt && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_disp_stream_buffer.sv
// Directed self-checking bench for disp_stream_buffer (DEPTH=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_disp_stream_buffer;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int DCW   = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [W-1:0]  s_axis_disp_tdata = '0;
    logic          s_axis_disp_tvalid = 1'b0;
    logic          s_axis_disp_tuser = 1'b0;
    logic          s_axis_disp_tlast = 1'b0;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [4:0]    fifo_level;
    logic          frame_drop;
    logic [DCW-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [W+1:0] exp_q[$];

    disp_stream_buffer #(
        .AXIS_TDATA_WIDTH(W),
        .DEPTH(DEPTH),
        .DROP_CNT_WIDTH(DCW)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_disp_tdata(s_axis_disp_tdata),
        .s_axis_disp_tvalid(s_axis_disp_tvalid),
        .s_axis_disp_tuser(s_axis_disp_tuser),
        .s_axis_disp_tlast(s_axis_disp_tlast),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .fifo_level(fifo_level),
        .frame_drop(frame_drop),
        .drop_cnt(drop_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] beat_data(input int f, input int i);
        return W'((f << 8) | i);
    endfunction

    // One clock: score a pop that is about to happen, then advance to the next falling edge.
    task automatic cycle();
        logic [W+1:0] e;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, e);
            end
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // Present one valid beat for one clock; optionally record it as expected downstream.
    task automatic send(input int f, input int i, input bit user, input bit last, input bit keep);
        s_axis_disp_tdata  = beat_data(f, i);
        s_axis_disp_tuser  = user;
        s_axis_disp_tlast  = last;
        s_axis_disp_tvalid = 1'b1;
        if (keep) exp_q.push_back({user, last, beat_data(f, i)});
        cycle();
        s_axis_disp_tvalid = 1'b0;
        s_axis_disp_tuser  = 1'b0;
        s_axis_disp_tlast  = 1'b0;
    endtask

    // Drain with tready high until the expected queue empties, bounded.
    task automatic drain();
        m_axis_tready = 1'b1;
        for (int k = 0; k < 100 && (exp_q.size() != 0 || m_axis_tvalid); k++) cycle();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_tvalid", 64'(m_axis_tvalid), 64'd0);
    endtask

    initial begin
        logic [W+1:0] head_exp;
        // Reset state
        repeat (2) @(negedge aclk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_user_last", 64'({m_axis_tuser, m_axis_tlast}), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_drop", 64'({frame_drop, drop_cnt}), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Startup sync: tuser=0 beats are discarded while waiting for a frame start
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) send(0, i, 1'b0, (i % 4) == 3, 1'b0);
        check("sync_level", 64'(fifo_level), 64'd0);
        check("sync_tvalid", 64'(m_axis_tvalid), 64'd0);

        // Passthrough: 4 lines x 4 beats, tready=1
        for (int i = 0; i < 16; i++) begin
            send(1, i, i == 0, (i % 4) == 3, 1'b1);
            if (i == 0) check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
            check("pass_level_le1", 64'(fifo_level <= 1), 64'd1);
        end
        drain();
        check("pass_drop_cnt", 64'(drop_cnt), 64'd0);

        // Backpressure: 12 beats stored while stalled, head stable
        m_axis_tready = 1'b0;
        for (int i = 0; i < 12; i++) send(2, i, i == 0, (i % 4) == 3, 1'b1);
        check("bp_level", 64'(fifo_level), 64'd12);
        head_exp = exp_q[0];
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_head_stable", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, head_exp);
        end
        drain();

        // Overflow: 20-beat frame into 16 entries with tready=0
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) send(3, i, i == 0, (i % 4) == 3, 1'b1);
        check("ovf_level_full", 64'(fifo_level), 64'd16);
        send(3, 16, 1'b0, 1'b0, 1'b0);
        check("ovf_frame_drop", 64'(frame_drop), 64'd1);
        check("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
        send(3, 17, 1'b0, 1'b0, 1'b0);
        check("ovf_pulse_once", 64'(frame_drop), 64'd0);
        send(3, 18, 1'b0, 1'b0, 1'b0);
        send(3, 19, 1'b0, 1'b1, 1'b0);
        check("ovf_level_held", 64'(fifo_level), 64'd16);
        drain();
        // next frame after draining resynchronises
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) send(4, i, i == 0, i == 3, 1'b1);
        drain();
        check("ovf_drop_cnt_final", 64'(drop_cnt), 64'd1);

        // Full with simultaneous push and pop
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) send(5, i, i == 0, (i % 4) == 3, 1'b1);
        check("full_level", 64'(fifo_level), 64'd16);
        m_axis_tready = 1'b1;
        send(5, 16, 1'b0, 1'b1, 1'b1);
        check("full_pushpop_level", 64'(fifo_level), 64'd16);
        check("full_pushpop_nodrop", 64'(frame_drop), 64'd0);
        check("full_pushpop_cnt", 64'(drop_cnt), 64'd1);
        drain();

        // Reset mid-frame with 8 beats buffered
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) send(6, i, i == 0, 1'b0, 1'b0);
        check("mid_level", 64'(fifo_level), 64'd8);
        #2 aresetn = 1'b0;
        #1;
        check("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("arst_level", 64'(fifo_level), 64'd0);
        check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        m_axis_tready = 1'b1;
        for (int i = 8; i < 11; i++) send(6, i, 1'b0, 1'b0, 1'b0);
        check("post_rst_sync_level", 64'(fifo_level), 64'd0);
        for (int i = 0; i < 2; i++) send(7, i, i == 0, i == 1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
